// File: rtl/dvi_video_pkg.sv
// rtl/dvi_video_pkg.sv - shared raster phase encoding, standard timings, total helper
// Purpose: phase-state encoding used by both raster axes, reference timing
// constants for 720p/1080p/480p, and a helper that sums phase lengths.
package dvi_video_pkg;

  // One encoding serves both axes; the H and V names are aliases of it.
  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  typedef phase_e h_state_e;
  typedef phase_e v_state_e;

  localparam int unsigned POS_W     = 12;
  localparam int unsigned MAX_TOTAL = 4096;

  // 1280x720 @ 60 Hz, 74.25 MHz
  localparam int unsigned P720_H_ACTIVE = 1280;
  localparam int unsigned P720_H_FP     = 110;
  localparam int unsigned P720_H_SYNC   = 40;
  localparam int unsigned P720_H_BP     = 220;
  localparam int unsigned P720_V_ACTIVE = 720;
  localparam int unsigned P720_V_FP     = 5;
  localparam int unsigned P720_V_SYNC   = 5;
  localparam int unsigned P720_V_BP     = 20;

  // 1920x1080 @ 60 Hz, 148.5 MHz
  localparam int unsigned P1080_H_ACTIVE = 1920;
  localparam int unsigned P1080_H_FP     = 88;
  localparam int unsigned P1080_H_SYNC   = 44;
  localparam int unsigned P1080_H_BP     = 148;
  localparam int unsigned P1080_V_ACTIVE = 1080;
  localparam int unsigned P1080_V_FP     = 4;
  localparam int unsigned P1080_V_SYNC   = 5;
  localparam int unsigned P1080_V_BP     = 36;

  // 640x480 @ 60 Hz, 25.175 MHz
  localparam int unsigned P480_H_ACTIVE = 640;
  localparam int unsigned P480_H_FP     = 16;
  localparam int unsigned P480_H_SYNC   = 96;
  localparam int unsigned P480_H_BP     = 48;
  localparam int unsigned P480_V_ACTIVE = 480;
  localparam int unsigned P480_V_FP     = 10;
  localparam int unsigned P480_V_SYNC   = 2;
  localparam int unsigned P480_V_BP     = 33;

  function automatic int unsigned calc_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/dvi_timing_axis.sv
// rtl/dvi_timing_axis.sv - one phase FSM plus position counter for a raster axis
// Purpose: walks ACT -> FP -> SYNC -> BP with a per-phase down-counter and a
// position counter that wraps together with the end of BP.
// Ports:
//   clk, reset_n   pixel clock, asynchronous active-low reset
//   restart_i      force position 0 / ACT (idle or first enabled edge)
//   advance_i      step one unit (every clock for H, on h wrap for V)
//   state_nxt_o    state this axis takes at the coming edge
//   pos_o          registered position
//   wrap_o         advance at the last position of the axis
module dvi_timing_axis
  import dvi_video_pkg::*;
#(
  parameter int unsigned ACTIVE = 8,
  parameter int unsigned FP     = 2,
  parameter int unsigned SYNC   = 3,
  parameter int unsigned BP     = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart_i,
  input  logic             advance_i,
  output phase_e           state_nxt_o,
  output logic [POS_W-1:0] pos_o,
  output logic             wrap_o
);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_phase
    $error("dvi_timing_axis: every phase length must be at least 1");
  end

  function automatic logic [POS_W-1:0] phase_len_m1(input phase_e s);
    case (s)
      PH_ACT:  return POS_W'(ACTIVE - 1);
      PH_FP:   return POS_W'(FP - 1);
      PH_SYNC: return POS_W'(SYNC - 1);
      default: return POS_W'(BP - 1);
    endcase
  endfunction

  function automatic phase_e phase_next(input phase_e s);
    case (s)
      PH_ACT:  return PH_FP;
      PH_FP:   return PH_SYNC;
      PH_SYNC: return PH_BP;
      default: return PH_ACT;
    endcase
  endfunction

  phase_e           state_q, state_d;
  logic [POS_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PH_ACT;
      cnt_q   <= phase_len_m1(PH_ACT);
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    if (restart_i) begin
      state_d = PH_ACT;
      cnt_d   = phase_len_m1(PH_ACT);
      pos_d   = '0;
    end else if (advance_i) begin
      pos_d = last ? '0 : pos_q + POS_W'(1);
      if (cnt_q == '0) begin
        state_d = phase_next(state_q);
        cnt_d   = phase_len_m1(state_d);
      end else begin
        cnt_d = cnt_q - POS_W'(1);
      end
    end
  end

  // The end of BP is by construction the last position, so the wrap needs no
  // comparison against the total.
  always_comb begin
    last        = (state_q == PH_BP) && (cnt_q == '0);
    wrap_o      = advance_i && !restart_i && last;
    state_nxt_o = state_d;
    pos_o       = pos_q;
  end

endmodule

// File: rtl/dvi_timing_gen.sv
// rtl/dvi_timing_gen.sv - DVI raster timing generator (sync, active qualifier, coordinates)
// Purpose: two chained axis FSMs plus registered, position-aligned outputs.
// Ports:
//   clk, reset_n              pixel clock, asynchronous active-low reset
//   enable                    run when high, idle (reset-value outputs) when low
//   active_pixel              inside both active regions
//   hsync_out, vsync_out      syncs at H_SYNC_POL / V_SYNC_POL when asserted
//   h_count, v_count          current raster position
//   line_start, frame_start   one-clock pulses at h=0 and at (0,0)
module dvi_timing_gen
  import dvi_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = P720_H_ACTIVE,
  parameter int unsigned H_FP       = P720_H_FP,
  parameter int unsigned H_SYNC     = P720_H_SYNC,
  parameter int unsigned H_BP       = P720_H_BP,
  parameter int unsigned V_ACTIVE   = P720_V_ACTIVE,
  parameter int unsigned V_FP       = P720_V_FP,
  parameter int unsigned V_SYNC     = P720_V_SYNC,
  parameter int unsigned V_BP       = P720_V_BP,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        active_pixel,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [11:0] h_count,
  output logic [11:0] v_count,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_too_big
    $error("dvi_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
  end

  logic   run_q, run_d;
  logic   active_q, active_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   line_start_q, line_start_d;
  logic   frame_start_q, frame_start_d;
  logic   restart;
  logic   h_wrap, v_wrap;
  phase_e h_state_nxt, v_state_nxt;

  // Both axes sit at (0,0) unless already running and still enabled, so the
  // first enabled edge lands on (0,0) rather than stepping past it.
  assign restart = !(run_q && enable);

  dvi_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk         (clk),
    .reset_n     (reset_n),
    .restart_i   (restart),
    .advance_i   (1'b1),
    .state_nxt_o (h_state_nxt),
    .pos_o       (h_count),
    .wrap_o      (h_wrap)
  );

  dvi_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk         (clk),
    .reset_n     (reset_n),
    .restart_i   (restart),
    .advance_i   (h_wrap),
    .state_nxt_o (v_state_nxt),
    .pos_o       (v_count),
    .wrap_o      (v_wrap)
  );

  // Outputs are computed from the axes' next state so they land on the same
  // edge as the position counters.
  always_comb begin
    run_d         = enable;
    active_d      = enable && (h_state_nxt == PH_ACT) && (v_state_nxt == PH_ACT);
    line_start_d  = enable && (!run_q || h_wrap);
    frame_start_d = enable && (!run_q || v_wrap);
    hsync_d       = (h_state_nxt == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d       = (v_state_nxt == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
    end else begin
      run_q         <= run_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign active_pixel = active_q;
  assign hsync_out    = hsync_q;
  assign vsync_out    = vsync_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// tb/tb_dvi_timing_gen.sv - self-checking bench for dvi_timing_gen
module tb_dvi_timing_gen;

  // Instance 0: small, positive syncs. 1: small, negative syncs. 2: 720p defaults.
  localparam int HA  [3] = '{8, 8, 1280};
  localparam int HF  [3] = '{2, 2, 110};
  localparam int HS  [3] = '{3, 3, 40};
  localparam int HB  [3] = '{3, 3, 220};
  localparam int VA  [3] = '{4, 4, 720};
  localparam int VF  [3] = '{1, 1, 5};
  localparam int VS  [3] = '{2, 2, 5};
  localparam int VB  [3] = '{1, 1, 20};
  localparam int POL [3] = '{1, 0, 1};

  typedef struct {
    int act, hs, vs, ls, fs, h, v;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic chk_en = 1'b0;

  logic [2:0]       d_act, d_hs, d_vs, d_ls, d_fs;
  logic [2:0][11:0] d_h, d_v;

  int mh   [3] = '{0, 0, 0};
  int mv   [3] = '{0, 0, 0};
  bit mrun [3] = '{0, 0, 0};

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dvi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .active_pixel(d_act[0]), .hsync_out(d_hs[0]), .vsync_out(d_vs[0]),
    .h_count(d_h[0]), .v_count(d_v[0]), .line_start(d_ls[0]), .frame_start(d_fs[0])
  );

  dvi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut_n (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .active_pixel(d_act[1]), .hsync_out(d_hs[1]), .vsync_out(d_vs[1]),
    .h_count(d_h[1]), .v_count(d_v[1]), .line_start(d_ls[1]), .frame_start(d_fs[1])
  );

  dvi_timing_gen dut_p (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .active_pixel(d_act[2]), .hsync_out(d_hs[2]), .vsync_out(d_vs[2]),
    .h_count(d_h[2]), .v_count(d_v[2]), .line_start(d_ls[2]), .frame_start(d_fs[2])
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
  endtask

  function automatic int htot(input int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vtot(input int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  // Expected outputs follow directly from the raster position.
  function automatic exp_t model_out(input int i);
    exp_t r;
    int   hs0, vs0;
    hs0  = HA[i] + HF[i];
    vs0  = VA[i] + VF[i];
    r.h  = mh[i];
    r.v  = mv[i];
    r.act = (mrun[i] && mh[i] < HA[i] && mv[i] < VA[i]) ? 1 : 0;
    r.hs  = (mrun[i] && mh[i] >= hs0 && mh[i] < hs0 + HS[i]) ? POL[i] : 1 - POL[i];
    r.vs  = (mrun[i] && mv[i] >= vs0 && mv[i] < vs0 + VS[i]) ? POL[i] : 1 - POL[i];
    r.ls  = (mrun[i] && mh[i] == 0) ? 1 : 0;
    r.fs  = (mrun[i] && mh[i] == 0 && mv[i] == 0) ? 1 : 0;
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n || !enable) begin
        mrun[i] <= 1'b0;
        mh[i]   <= 0;
        mv[i]   <= 0;
      end else if (!mrun[i]) begin
        mrun[i] <= 1'b1;
        mh[i]   <= 0;
        mv[i]   <= 0;
      end else if (mh[i] == htot(i) - 1) begin
        mh[i] <= 0;
        mv[i] <= (mv[i] == vtot(i) - 1) ? 0 : mv[i] + 1;
      end else begin
        mh[i] <= mh[i] + 1;
      end
    end
  end

  exp_t e;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        e = model_out(i);
        check($sformatf("i%0d active_pixel h%0d v%0d", i, e.h, e.v), int'(d_act[i]), e.act);
        check($sformatf("i%0d hsync_out h%0d v%0d", i, e.h, e.v), int'(d_hs[i]), e.hs);
        check($sformatf("i%0d vsync_out h%0d v%0d", i, e.h, e.v), int'(d_vs[i]), e.vs);
        check($sformatf("i%0d line_start h%0d v%0d", i, e.h, e.v), int'(d_ls[i]), e.ls);
        check($sformatf("i%0d frame_start h%0d v%0d", i, e.h, e.v), int'(d_fs[i]), e.fs);
        check($sformatf("i%0d h_count", i), int'(d_h[i]), e.h);
        check($sformatf("i%0d v_count", i), int'(d_v[i]), e.v);
      end
    end
  end

  initial begin
    int n_act, n_vs, n_vsn, n_hs, n_ls, n_fs;
    int rise_h, rise_v, hs_first, hs_last, act_hmax, act_vmax;
    int w;
    logic prev_vs;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset h_count", int'(d_h[0]), 0);
    check("reset v_count", int'(d_v[0]), 0);
    check("reset active_pixel", int'(d_act[0]), 0);
    check("reset frame_start", int'(d_fs[0]), 0);
    check("reset hsync pos", int'(d_hs[0]), 0);
    check("reset hsync neg", int'(d_hs[1]), 1);
    check("reset vsync neg", int'(d_vs[1]), 1);

    // Release with enable high: first edge lands on (0,0).
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    check("start h_count", int'(d_h[0]), 0);
    check("start v_count", int'(d_v[0]), 0);
    check("start active_pixel", int'(d_act[0]), 1);
    check("start frame_start", int'(d_fs[0]), 1);
    check("start line_start", int'(d_ls[0]), 1);

    // One full small frame of 128 clocks.
    n_act = 0; n_vs = 0; n_vsn = 0; n_hs = 0; n_ls = 0; n_fs = 0;
    rise_h = -1; rise_v = -1; hs_first = -1; hs_last = -1; act_hmax = -1; act_vmax = -1;
    prev_vs = 1'b0;
    for (int k = 0; k < 128; k++) begin
      n_act += int'(d_act[0]);
      n_vs  += int'(d_vs[0]);
      n_vsn += int'(!d_vs[1]);
      n_hs  += int'(d_hs[0]);
      n_ls  += int'(d_ls[0]);
      n_fs  += int'(d_fs[0]);
      if (d_vs[0] && !prev_vs && rise_h < 0) begin
        rise_h = int'(d_h[0]);
        rise_v = int'(d_v[0]);
      end
      prev_vs = d_vs[0];
      if (d_v[0] == 12'd0 && d_hs[0]) begin
        if (hs_first < 0) hs_first = int'(d_h[0]);
        hs_last = int'(d_h[0]);
      end
      if (d_act[0]) begin
        if (int'(d_h[0]) > act_hmax) act_hmax = int'(d_h[0]);
        if (int'(d_v[0]) > act_vmax) act_vmax = int'(d_v[0]);
      end
      @(negedge clk);
    end
    check("frame active pixels", n_act, 32);
    check("frame vsync clocks", n_vs, 32);
    check("frame vsync clocks neg pol", n_vsn, 32);
    check("frame hsync clocks", n_hs, 24);
    check("frame line_start pulses", n_ls, 8);
    check("frame frame_start pulses", n_fs, 1);
    check("vsync rise h_count", rise_h, 0);
    check("vsync rise v_count", rise_v, 5);
    check("hsync first h_count", hs_first, 10);
    check("hsync last h_count", hs_last, 12);
    check("active max h_count", act_hmax, 7);
    check("active max v_count", act_vmax, 3);
    check("frame_start recurs at 128", int'(d_fs[0]), 1);
    check("recur h_count", int'(d_h[0]), 0);
    check("recur v_count", int'(d_v[0]), 0);

    // Drop enable at (5,2), restore three clocks later.
    w = 0;
    while (!(d_h[0] == 12'd5 && d_v[0] == 12'd2) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("reached h5 v2", (w < 300) ? 1 : 0, 1);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle h_count", int'(d_h[0]), 0);
      check("idle v_count", int'(d_v[0]), 0);
      check("idle active_pixel", int'(d_act[0]), 0);
      check("idle line_start", int'(d_ls[0]), 0);
      check("idle hsync neg", int'(d_hs[1]), 1);
    end
    enable = 1'b1;
    @(negedge clk);
    check("restart h_count", int'(d_h[0]), 0);
    check("restart v_count", int'(d_v[0]), 0);
    check("restart frame_start", int'(d_fs[0]), 1);
    check("restart active_pixel", int'(d_act[0]), 1);

    // Asynchronous reset mid-line at h=9, checked before the next clock edge.
    w = 0;
    while (d_h[0] != 12'd9 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("reached h9", (w < 40) ? 1 : 0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst h_count", int'(d_h[0]), 0);
    check("async rst v_count", int'(d_v[0]), 0);
    check("async rst active_pixel", int'(d_act[0]), 0);
    check("async rst hsync pos", int'(d_hs[0]), 0);
    check("async rst hsync neg", int'(d_hs[1]), 1);
    check("async rst vsync neg", int'(d_vs[1]), 1);
    check("async rst 720p h_count", int'(d_h[2]), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset frame_start", int'(d_fs[2]), 1);

    // One 720p line.
    n_hs = 0; n_act = 0; n_ls = 0; hs_first = -1;
    for (int k = 0; k < 1650; k++) begin
      n_hs  += int'(d_hs[2]);
      n_act += int'(d_act[2]);
      n_ls  += int'(d_ls[2]);
      if (d_hs[2] && hs_first < 0) hs_first = int'(d_h[2]);
      @(negedge clk);
    end
    check("720p hsync width", n_hs, 40);
    check("720p active per line", n_act, 1280);
    check("720p line_start per line", n_ls, 1);
    check("720p hsync first h_count", hs_first, 1390);
    check("720p line wrap h_count", int'(d_h[2]), 0);
    check("720p line wrap v_count", int'(d_v[2]), 1);
    check("720p line wrap line_start", int'(d_ls[2]), 1);

    repeat (1700) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
- Raster timing generator for the DVI output path.
- Produces hsync/vsync, the active-pixel qualifier and pixel/line coordinates, all on the pixel clock.
- Directly feeds the test-pattern stage through active_pixel, hsync_in and vsync_in, and feeds the DVI transmitter sync inputs.
- Timing is fully parameterised; defaults are 1280x720 at 60 Hz (74.25 MHz pixel clock).

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, horizontal sync width (clocks)
H_BP, 220, horizontal back porch (clocks)
V_ACTIVE, 720, visible lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BP, 20, vertical back porch (lines)
H_SYNC_POL, 1, asserted level of hsync_out
V_SYNC_POL, 1, asserted level of vsync_out

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run timing when high; idle when low
active_pixel  out  1  high when the current position is inside both H_ACTIVE and V_ACTIVE
hsync_out  out  1  horizontal sync at H_SYNC_POL
vsync_out  out  1  vertical sync at V_SYNC_POL
h_count  out  12  horizontal position, 0..H_TOTAL-1
v_count  out  12  vertical position, 0..V_TOTAL-1
line_start  out  1  one-clock pulse at h_count==0
frame_start  out  1  one-clock pulse at h_count==0 && v_count==0

Behaviour:
Totals and reset
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
- Both totals must be <= 4096; elaborate-time check.
- Reset (async assert, sync release): h_count=0, v_count=0, active_pixel=0, line_start=0, frame_start=0; hsync_out=~H_SYNC_POL, vsync_out=~V_SYNC_POL (deasserted); internal run flag cleared.

Idle and start
- Idle state means run flag low and all outputs at their reset values.
- First rising edge with enable=1 while idle sets the run flag and loads position (0,0). All outputs reflect (0,0) in that same cycle: active_pixel=1, line_start=1, frame_start=1.

Running
- Each clock h_count increments.
- At h_count==H_TOTAL-1, h_count wraps to 0 and v_count increments.
- At v_count==V_TOTAL-1 with h_count wrap, v_count wraps to 0.
- All outputs are registered and aligned to the same position as h_count/v_count (zero relative latency).
- Horizontal FSM, states H_ACT, H_FP, H_SYNC, H_BP:
  - An internal phase counter loads the phase length-1 on entry; the state advances when the counter reaches 0.
  - H_BP advances to H_ACT together with the h wrap.
- Vertical FSM, states V_ACT, V_FP, V_SYNC, V_BP: same structure, advanced only on the h wrap.
- hsync_out = H_SYNC_POL iff H state is H_SYNC; vsync_out = V_SYNC_POL iff V state is V_SYNC.
- vsync edges coincide with the h wrap (line start), not with hsync.
- active_pixel = (H state==H_ACT) && (V state==V_ACT).
- The FSM state and counter-derived position must always agree; the bench checks this.

Boundary conditions
- enable falling while running: the next edge returns to idle (reset-value outputs).
- enable re-rising: restart at (0,0) with frame_start.
- reset_n assert mid-line: outputs take reset values immediately (asynchronous).
- Any phase parameter of 0 is illegal; elaborate-time error.
- Phase length of 1: the state occupies exactly one clock or one line.

Decomposition:
- Shared package (dvi_video_pkg): H/V FSM state encodings, 720p/1080p/480p timing constants, helper function computing totals.
- Sub-module dvi_timing_axis: one generic phase FSM plus counter, instantiated twice.
  - Horizontal instance: advance=1 every clock.
  - Vertical instance: advance=h wrap.
  - Outputs: state, wrap pulse, position count.

Test Plan:
- Small params (H 8/2/3/3, V 4/1/2/1, H_TOTAL=16, V_TOTAL=8), release reset with enable=1:
  - first edge gives h_count=0, v_count=0, active_pixel=1, frame_start=1.
  - frame_start recurs every 128 clocks.
- Same params, one line: active_pixel high for h_count 0..7; hsync_out high exactly for h_count 10..12; line_start pulses at h_count 0 only.
- Same params, full frame: vsync_out high for v_count 5..6 (32 clocks, rising at h_count=0); active_pixel=0 for all of v_count 4..7; exactly 32 active pixels per frame.
- H_SYNC_POL=0, V_SYNC_POL=0: sync levels inverted (idle 1, asserted 0); reset value of both syncs is 1.
- enable dropped at h_count=5, v_count=2, restored 3 clocks later: outputs idle meanwhile; restart at (0,0) with frame_start=1.
- reset_n asserted mid-frame at h_count=9: outputs reach reset values within the same clock period, without waiting for a clock edge.
- Default 720p params: 1650 clocks/line and 750 lines/frame; hsync width 40, vsync width 5 lines; 921600 active pixels per frame.
